stack_unit: RTL and testbench
=============================

# stack_unit

Hardware return/data stack serving the processor's stack instructions: push, pop, call (JSR) and return (RET). The control unit issues one request at a time over a valid/ready handshake. The block stores the word, or returns the top word, and signals completion with a one-cycle response pulse. It owns the stack memory and occupancy count and flags overflow and underflow without corrupting state.

## Interface
- DATA_W, 8, width of stacked words (data bytes and return PCs)
- DEPTH, 16, number of stack entries; power of two, ≥ 2
- AW, 4, log2(DEPTH)

- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  control unit presents a request
- req_ready  out  1  block can accept a request this cycle
- req_op  in  2  00 push, 01 pop, 10 call, 11 ret
- req_data  in  DATA_W  word to store (push: GPR data; call: return PC)
- flush  in  1  synchronous clear of stack contents (count only)
- rsp_valid  out  1  one-cycle completion pulse
- rsp_data  out  DATA_W  popped word (pop/ret); 0 for push/call or error
- rsp_err  out  1  valid with rsp_valid: overflow (push/call when full) or underflow (pop/ret when empty)
- count  out  AW+1  current occupancy, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0

## Operation
- Storage: DEPTH×DATA_W register array, not reset. Entry i is valid for i < count. The top of stack is entry count-1.
- Push and call are identical in datapath; pop and ret are identical. The op codes stay distinct for debug only.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: req_ready=1 unless flush=1. On req_valid && req_ready, latch op and data, then go to EXEC.
  - EXEC, push/call, not full: mem[count] <= data; count <= count+1.
  - EXEC, push/call, full: no write; err flag set.
  - EXEC, pop/ret, not empty: rd_reg <= mem[count-1]; count <= count-1.
  - EXEC, pop/ret, empty: no change; err flag set. EXEC always goes to RESP.
  - RESP: rsp_valid=1, rsp_data=rd_reg (pop/ret success) else 0, rsp_err=err. Go to IDLE.
- Flush: honoured only in IDLE; count <= 0 next edge. In EXEC/RESP it is ignored, and the caller must hold it until req_ready rises.
- Flush and req_valid in the same IDLE cycle: flush wins, request is not accepted (req_ready=0), and the request stays pending.
- Request inputs are ignored outside the IDLE handshake cycle.
- full/empty are combinational from count.
- Error never changes count or memory.

## Timing
- Reset (rst=0, any state, immediate): state IDLE, count=0, rsp_valid=0, rsp_data=0, rsp_err=0, rd_reg=0, err=0. Outputs after reset: req_ready=1, full=0, empty=1. Memory contents undefined. A request in flight is discarded with no response.
- Latency: handshake at edge N; count updates at edge N+1; rsp_valid is high in cycle N+1→N+2; req_ready returns high in the cycle after RESP.
- Throughput: one request per 3 cycles. req_ready=0 during EXEC and RESP.
- rsp_valid, rsp_data and rsp_err are registered and are never asserted in IDLE.
- Wrap: count never exceeds DEPTH or goes below 0. Array index uses count[AW-1:0]; a write at count=DEPTH is impossible because full blocks it.

## Test plan
- Reset then push 0xA5, pop → push response rsp_err=0, rsp_data=0x00, count=1. Pop response rsp_data=0xA5, count=0, empty=1.
- Call 0x12, push 0x34, pop, ret → pop returns 0x34, ret returns 0x12 (LIFO), count back to 0, every response rsp_err=0.
- Push 16 distinct values 0x00..0x0F, then push 0xFF → 16th push sets full=1. 17th push gives rsp_err=1, count stays 16. Then 16 pops return 0x0F..0x00 in order.
- Pop on empty after reset → rsp_valid pulse with rsp_err=1, rsp_data=0, count=0.
- Push 3 values, then assert flush together with req_valid(pop) in IDLE → req_ready=0 that cycle, count=0 next cycle. Pop accepted after flush drops and returns rsp_err=1.
- Push 0x55 and assert rst=0 during EXEC → outputs clear immediately, no rsp_valid. After release: count=0, req_ready=1, next pop gives rsp_err=1.

Source files
------------

// File: rtl/stack_unit_if.sv
// Request/response channel between the control unit and the stack unit.
// The control unit drives requests; the stack unit drives ready and response.
interface stack_unit_if #(
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [DATA_W-1:0] req_data;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    modport master (
        output req_valid, req_op, req_data,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_data,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/stack_unit.sv
// Hardware return/data stack: push/call store a word, pop/ret return the top word.
// One request at a time, IDLE -> EXEC -> RESP, with overflow/underflow flagged.
module stack_unit #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic          clk,
    input  logic          rst,
    stack_unit_if.slave   bus,
    input  logic          flush,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);
    localparam logic [1:0]    OP_POP   = 2'b01;
    localparam logic [1:0]    OP_RET   = 2'b11;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] IDX_ONE  = AW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    state_t            r_state;
    logic [AW:0]       r_count;
    logic [1:0]        r_op;
    logic [DATA_W-1:0] r_data;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_err;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_full;
    logic              w_empty;
    logic              w_ready;
    logic              w_accept;
    logic              w_is_pop;
    logic              w_wr;
    logic [AW-1:0]     w_wr_idx;
    logic [AW-1:0]     w_top_idx;

    assign w_full    = (r_count == FULL_CNT);
    assign w_empty   = (r_count == '0);
    assign w_ready   = (r_state == S_IDLE) && !flush;
    assign w_accept  = w_ready && bus.req_valid;
    assign w_is_pop  = (r_op == OP_POP) || (r_op == OP_RET);
    assign w_wr      = (r_state == S_EXEC) && !w_is_pop && !w_full;
    assign w_wr_idx  = r_count[AW-1:0];
    assign w_top_idx = r_count[AW-1:0] - IDX_ONE;

    // Control state and registered response; flush only acts while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_op        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (flush) begin
                        r_count <= '0;
                    end else if (bus.req_valid) begin
                        r_op    <= bus.req_op;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                    if (w_is_pop) begin
                        if (w_empty) begin
                            r_rsp_err <= 1'b1;
                        end else begin
                            r_rsp_data <= r_mem[w_top_idx];
                            r_count    <= r_count - CNT_ONE;
                        end
                    end else begin
                        if (w_full) begin
                            r_rsp_err <= 1'b1;
                        end else begin
                            r_count <= r_count + CNT_ONE;
                        end
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Storage and the latched request word are plain data, never reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_data <= bus.req_data;
        end
        if (w_wr) begin
            r_mem[w_wr_idx] <= r_data;
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;
    assign count         = r_count;
    assign full          = w_full;
    assign empty         = w_empty;
endmodule

// File: tb/tb_stack_unit.sv
// Scoreboard bench for stack_unit: a queue-based LIFO model predicts each
// response, and an independent monitor checks responses as they appear.
module tb_stack_unit;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic [AW:0]   count;
    logic          full;
    logic          empty;

    stack_unit_if #(.DATA_W(DW)) bus ();

    stack_unit #(.DATA_W(DW), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk   (clk),
        .rst   (rst_n),
        .bus   (bus),
        .flush (flush),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [DW-1:0] d;
        logic          e;
        logic [AW:0]   c;
    } exp_t;

    exp_t          sbq[$];
    logic [DW-1:0] model[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference stack: push/call append, pop/ret take the newest entry.
    function automatic exp_t predict(input logic [1:0] op, input logic [DW-1:0] d);
        exp_t x;
        x.d = '0;
        x.e = 1'b0;
        if (op == 2'b00 || op == 2'b10) begin
            if (model.size() == DEPTH) x.e = 1'b1;
            else model.push_back(d);
        end else begin
            if (model.size() == 0) x.e = 1'b1;
            else x.d = model.pop_back();
        end
        x.c = (AW+1)'(model.size());
        return x;
    endfunction

    task automatic do_req(input logic [1:0] op, input logic [DW-1:0] d);
        int t = 0;
        while (bus.req_ready !== 1'b1) begin
            @(posedge clk); #1;
            t++;
            if (t > 20) begin
                check("ready_timeout", 32'd0, 32'd1);
                return;
            end
        end
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_data  = d;
        sbq.push_back(predict(op, d));
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'($urandom);
        bus.req_data  = DW'($urandom);
    endtask

    task automatic drain();
        int t = 0;
        while (sbq.size() != 0 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_timeout", 32'(sbq.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    // Response monitor, sampling on the falling edge.
    logic prev_vld = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.rsp_valid === 1'b1) begin
                exp_t x;
                check("rsp_pulse", 32'(prev_vld), 32'd0);
                if (sbq.size() == 0) begin
                    check("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    x = sbq.pop_front();
                    check("rsp_data", 32'(bus.rsp_data), 32'(x.d));
                    check("rsp_err", 32'(bus.rsp_err), 32'(x.e));
                    check("rsp_count", 32'(count), 32'(x.c));
                end
            end
            prev_vld = bus.rsp_valid;
        end
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(bus.req_ready), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        do_req(2'b00, 8'hA5);
        do_req(2'b01, 8'h00);
        drain();
        check("empty_after_pop", 32'(empty), 32'd1);

        do_req(2'b10, 8'h12);
        do_req(2'b00, 8'h34);
        do_req(2'b01, 8'h00);
        do_req(2'b11, 8'h00);
        drain();

        for (int i = 0; i < DEPTH; i++) do_req(2'b00, DW'(i));
        drain();
        check("full_flag", 32'(full), 32'd1);
        check("full_count", 32'(count), 32'(DEPTH));
        do_req(2'b00, 8'hFF);
        for (int i = 0; i < DEPTH; i++) do_req(2'b01, 8'h00);
        drain();

        do_req(2'b01, 8'h00);
        drain();

        for (int i = 0; i < 3; i++) do_req(2'b00, DW'(8'h70 + i));
        drain();
        flush         = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b01;
        bus.req_data  = 8'h00;
        #1;
        check("flush_ready_low", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
        check("flush_count", 32'(count), 32'd0);
        check("flush_empty", 32'(empty), 32'd1);
        model.delete();
        flush = 1'b0;
        sbq.push_back(predict(2'b01, 8'h00));
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        drain();

        do_req(2'b00, 8'h11);
        drain();
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b00;
        bus.req_data  = 8'h55;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("arst_count", 32'(count), 32'd0);
        check("arst_ready", 32'(bus.req_ready), 32'd1);
        model.delete();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_count", 32'(count), 32'd0);
        check("post_rst_ready", 32'(bus.req_ready), 32'd1);
        do_req(2'b01, 8'h00);
        drain();

        for (int i = 0; i < 300; i++) begin
            logic [1:0] op;
            int         push_bias;
            push_bias = (i < 150) ? 7 : 3;
            op[0] = ($urandom_range(0, 9) < push_bias) ? 1'b0 : 1'b1;
            op[1] = 1'($urandom);
            do_req(op, DW'($urandom));
        end
        drain();
        check("final_count", 32'(count), 32'(model.size()));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
